// File: rtl/adder_share_arb.sv
// adder_share_arb: arbitrates NUM_REQ requesters onto one shared registered adder
// (ADD_LAT-edge latency). It tracks each issued op's requester ID alongside the
// adder and returns registered, tagged results in issue order.
// Build option ADD_ARB_ROUND_ROBIN_EN selects the arbitration policy:
// round-robin when defined, fixed priority (lowest index wins) otherwise.
module adder_share_arb #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int ADD_LAT = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic                        Hold,
  input  logic [NUM_REQ-1:0]          ReqValid,
  input  logic [NUM_REQ*DATA_W-1:0]   ReqA,
  input  logic [NUM_REQ*DATA_W-1:0]   ReqB,
  input  logic [NUM_REQ-1:0]          ReqCin,
  output logic [NUM_REQ-1:0]          ReqReady,
  output logic [DATA_W-1:0]           AddA,
  output logic [DATA_W-1:0]           AddB,
  output logic                        AddCin,
  input  logic [DATA_W-1:0]           AddS,
  input  logic                        AddCout,
  output logic                        RspValid,
  output logic [ID_W-1:0]             RspId,
  output logic [DATA_W-1:0]           RspS,
  output logic                        RspCout,
  output logic [1:0]                  InFlight
);

  localparam int unsigned NREQ_U = NUM_REQ;

  logic                 grant_any;
  logic [ID_W-1:0]      grant_id;
  logic [NUM_REQ-1:0]   grant_vec;
  logic [ID_W-1:0]      idx;
  logic [DATA_W-1:0]    add_a;
  logic [DATA_W-1:0]    add_b;
  logic                 add_cin;

  logic [ADD_LAT-1:0]   tag_vld_q, tag_vld_d;
  logic [ID_W-1:0]      tag_id_q [ADD_LAT];
  logic [ID_W-1:0]      tag_id_d [ADD_LAT];

  logic                 rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]      rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0]    rsp_s_q, rsp_s_d;
  logic                 rsp_cout_q, rsp_cout_d;
  logic [1:0]           in_flight_q, in_flight_d;

`ifdef ADD_ARB_ROUND_ROBIN_EN
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
`endif

  // Pick at most one valid requester and route its operands to the adder.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    grant_vec = '0;
    idx       = '0;
    add_a     = '0;
    add_b     = '0;
    add_cin   = 1'b0;
    if (!Rst && !Hold) begin
      for (int unsigned k = 0; k < NREQ_U; k++) begin
`ifdef ADD_ARB_ROUND_ROBIN_EN
        idx = ID_W'((k + 32'(rr_ptr_q)) % NREQ_U);
`else
        idx = ID_W'(k);
`endif
        if (!grant_any && ReqValid[idx]) begin
          grant_any      = 1'b1;
          grant_id       = idx;
          grant_vec[idx] = 1'b1;
          add_a          = ReqA[idx*DATA_W +: DATA_W];
          add_b          = ReqB[idx*DATA_W +: DATA_W];
          add_cin        = ReqCin[idx];
        end
      end
    end
  end

`ifdef ADD_ARB_ROUND_ROBIN_EN
  // Advance the round-robin pointer past the winner on every grant.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_any) begin
      rr_ptr_d = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : ID_W'(grant_id + 1'b1);
    end
  end
`endif

  // Tag pipeline mirrors the adder latency; its last stage loads the response.
  always_comb begin
    tag_vld_d[0] = grant_any;
    tag_id_d[0]  = grant_id;
    for (int unsigned s = 1; s < ADD_LAT; s++) begin
      tag_vld_d[s] = tag_vld_q[s-1];
      tag_id_d[s]  = tag_id_q[s-1];
    end
    rsp_valid_d = tag_vld_q[ADD_LAT-1];
    rsp_id_d    = rsp_id_q;
    rsp_s_d     = rsp_s_q;
    rsp_cout_d  = rsp_cout_q;
    if (tag_vld_q[ADD_LAT-1]) begin
      rsp_id_d   = tag_id_q[ADD_LAT-1];
      rsp_s_d    = AddS;
      rsp_cout_d = AddCout;
    end
    case ({grant_any, rsp_valid_d})
      2'b10:   in_flight_d = in_flight_q + 2'd1;
      2'b01:   in_flight_d = in_flight_q - 2'd1;
      default: in_flight_d = in_flight_q;
    endcase
  end

  // All state registers; reset discards every in-flight op.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      tag_vld_q <= '0;
      for (int unsigned s = 0; s < ADD_LAT; s++) begin
        tag_id_q[s] <= '0;
      end
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_s_q     <= '0;
      rsp_cout_q  <= 1'b0;
      in_flight_q <= '0;
`ifdef ADD_ARB_ROUND_ROBIN_EN
      rr_ptr_q    <= '0;
`endif
    end else begin
      tag_vld_q <= tag_vld_d;
      for (int unsigned s = 0; s < ADD_LAT; s++) begin
        tag_id_q[s] <= tag_id_d[s];
      end
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_s_q     <= rsp_s_d;
      rsp_cout_q  <= rsp_cout_d;
      in_flight_q <= in_flight_d;
`ifdef ADD_ARB_ROUND_ROBIN_EN
      rr_ptr_q    <= rr_ptr_d;
`endif
    end
  end

  assign ReqReady = grant_vec;
  assign AddA     = add_a;
  assign AddB     = add_b;
  assign AddCin   = add_cin;
  assign RspValid = rsp_valid_q;
  assign RspId    = rsp_id_q;
  assign RspS     = rsp_s_q;
  assign RspCout  = rsp_cout_q;
  assign InFlight = in_flight_q;

endmodule

// File: tb/tb_adder_share_arb.sv
// Scoreboard bench for adder_share_arb: a driver predicts grants and results from
// the arbitration rules and queues expected responses; a monitor checks Rsp*.
module tb_adder_share_arb;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int LAT = 2;

  logic           Clk = 1'b0;
  logic           Rst = 1'b1;
  logic           Hold = 1'b0;
  logic [N-1:0]   ReqValid = '0;
  logic [N*W-1:0] ReqA = '0;
  logic [N*W-1:0] ReqB = '0;
  logic [N-1:0]   ReqCin = '0;
  logic [N-1:0]   ReqReady;
  logic [W-1:0]   AddA, AddB, AddS;
  logic           AddCin, AddCout;
  logic           RspValid;
  logic [1:0]     RspId;
  logic [W-1:0]   RspS;
  logic           RspCout;
  logic [1:0]     InFlight;

  adder_share_arb #(.NUM_REQ(N), .DATA_W(W), .ADD_LAT(LAT)) dut (
    .Clk(Clk), .Rst(Rst), .Hold(Hold), .ReqValid(ReqValid), .ReqA(ReqA), .ReqB(ReqB),
    .ReqCin(ReqCin), .ReqReady(ReqReady), .AddA(AddA), .AddB(AddB), .AddCin(AddCin),
    .AddS(AddS), .AddCout(AddCout), .RspValid(RspValid), .RspId(RspId), .RspS(RspS),
    .RspCout(RspCout), .InFlight(InFlight)
  );

  always #5 Clk = ~Clk;

  // Shared adder stand-in: input registers, then registered sum; no reset.
  logic [W-1:0] ad_a, ad_b;
  logic         ad_c;
  always @(posedge Clk) begin
    ad_a <= AddA;
    ad_b <= AddB;
    ad_c <= AddCin;
    {AddCout, AddS} <= {1'b0, ad_a} + {1'b0, ad_b} + {{W{1'b0}}, ad_c};
  end

  typedef struct {
    int         id;
    logic [8:0] sum;
    int         edge_no;
  } exp_t;

  exp_t     q[$];
  int       n_cmp = 0;
  int       n_bad = 0;
  int       cyc = 0;
  int       ptr_m = 0;
  logic [7:0] op_a [N];
  logic [7:0] op_b [N];
  logic       op_c [N];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference arbitration: first valid requester scanning from the pointer.
  function automatic int exp_grant(input logic [N-1:0] v, input logic h);
    if (h || v == '0) return -1;
    for (int k = 0; k < N; k++) begin
      if (v[(ptr_m + k) % N]) return (ptr_m + k) % N;
    end
    return -1;
  endfunction

  task automatic drive(input logic h, input logic [N-1:0] v);
    int g;
    logic [N-1:0] er;
    exp_t e;
    @(negedge Clk);
    Hold = h;
    ReqValid = v;
    for (int i = 0; i < N; i++) begin
      ReqA[i*W +: W] = op_a[i];
      ReqB[i*W +: W] = op_b[i];
      ReqCin[i]      = op_c[i];
    end
    #1;
    g = exp_grant(v, h);
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    check("ReqReady", 32'(ReqReady), 32'(er));
    if (g >= 0) begin
      check("AddOperands", {15'd0, AddA, AddB, AddCin}, {15'd0, op_a[g], op_b[g], op_c[g]});
      e.id = g;
      e.sum = {1'b0, op_a[g]} + {1'b0, op_b[g]} + {8'd0, op_c[g]};
      e.edge_no = cyc + 1;
      q.push_back(e);
`ifdef ADD_ARB_ROUND_ROBIN_EN
      ptr_m = (g + 1) % N;
`endif
    end else begin
      check("AddOperandsIdle", {15'd0, AddA, AddB, AddCin}, 32'd0);
    end
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b, input logic c);
    op_a[i] = a;
    op_b[i] = b;
    op_c[i] = c;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge Clk);
    Rst = 1'b1;
    Hold = 1'b0;
    ReqValid = '1;
    q.delete();
    ptr_m = 0;
    #1;
    check("RstReqReady", 32'(ReqReady), 32'd0);
    check("RstAddOps", {15'd0, AddA, AddB, AddCin}, 32'd0);
    check("RstRsp", {20'd0, RspValid, RspId, RspS, RspCout}, 32'd0);
    check("RstInFlight", 32'(InFlight), 32'd0);
    repeat (cycles) @(negedge Clk);
    ReqValid = '0;
    Rst = 1'b0;
  endtask

  // Monitor: compare each presented response against the head of the queue.
  always begin
    exp_t e;
    @(posedge Clk);
    cyc = cyc + 1;
    #1;
    if (RspValid) begin
      if (q.size() == 0) begin
        check("UnexpectedRspValid", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        check("RspId", 32'(RspId), 32'(e.id));
        check("RspSum", {23'd0, RspCout, RspS}, {23'd0, e.sum});
        check("RspLatency", 32'(cyc), 32'(e.edge_no + LAT));
      end
    end
    check("InFlight", 32'(InFlight), 32'(q.size()));
  end

  initial begin
    for (int i = 0; i < N; i++) set_op(i, 8'h00, 8'h00, 1'b0);
    do_reset(2);

    // single op, then carry case
    set_op(0, 8'h0F, 8'h01, 1'b0);
    drive(1'b0, 4'b0001);
    repeat (4) drive(1'b0, 4'b0000);
    set_op(2, 8'hFF, 8'h00, 1'b1);
    drive(1'b0, 4'b0100);
    repeat (4) drive(1'b0, 4'b0000);

    // all requesters valid continuously
    set_op(0, 8'h11, 8'h22, 1'b0);
    set_op(1, 8'h80, 8'h80, 1'b0);
    set_op(2, 8'h7F, 8'h01, 1'b1);
    set_op(3, 8'hA5, 8'h5A, 1'b1);
    repeat (6) drive(1'b0, 4'b1111);
    repeat (4) drive(1'b0, 4'b0000);

    // hold blocks new grants, release grants immediately
    repeat (5) drive(1'b1, 4'b0010);
    drive(1'b0, 4'b0010);
    repeat (4) drive(1'b0, 4'b0000);

    // req1 then req1|req3: pointer moves past 1, then wraps
    drive(1'b0, 4'b0010);
    drive(1'b0, 4'b1010);
    drive(1'b0, 4'b1010);
    repeat (4) drive(1'b0, 4'b0000);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < N; i++) set_op(i, 8'($urandom), 8'($urandom), 1'($urandom));
      drive(($urandom_range(0, 7) == 0), 4'($urandom));
    end

    // three back-to-back issues, then reset while ops are still in the pipe
    for (int i = 0; i < N; i++) set_op(i, 8'($urandom), 8'($urandom), 1'($urandom));
    repeat (3) drive(1'b0, 4'b1111);
    drive(1'b0, 4'b0000);
    do_reset(1);
    repeat (6) drive(1'b0, 4'b0000);

    // more random traffic after reset, then drain
    for (int n = 0; n < 200; n++) begin
      for (int i = 0; i < N; i++) set_op(i, 8'($urandom), 8'($urandom), 1'($urandom));
      drive(($urandom_range(0, 5) == 0), 4'($urandom));
    end
    repeat (6) drive(1'b0, 4'b0000);
    check("QueueDrained", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
